// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory bus between instruction fetch and data access.
// Data requests win arbitration (the MEM-stage instruction is older). Read data is
// held, with a done flag, until the pipeline advances. A watchdog can abort a
// transaction whose bus never acknowledges.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [DW/8-1:0]   mem_be,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_wdata,
    output logic [DW-1:0]     mem_rdata,
    input  logic              advance,
    input  logic              flush,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              stall_req,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DW/8-1:0]   bus_be,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    input  logic              bus_ack,
    input  logic [DW-1:0]     bus_rdata,
    output logic              bus_err
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic WDOG_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic            bus_req_q,   bus_req_d;
    logic            bus_we_q,    bus_we_d;
    logic [BW-1:0]   bus_be_q,    bus_be_d;
    logic [AW-1:0]   bus_addr_q,  bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW-1:0]   if_rdata_q,  if_rdata_d;
    logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
    logic            if_done_q,   if_done_d;
    logic            mem_done_q,  mem_done_d;
    logic            discard_q,   discard_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            bus_err_q,   bus_err_d;

    logic            timeout_hit;
    logic            discard_now;
    logic            txn_end;

    // Stalls are combinational so a request stalls the pipe in the very cycle it appears.
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = mem_req & ~mem_done_q;
    assign stall_req = stall_if | stall_mem;

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    // Next-state: arbitration, bus sequencing, result capture and watchdog.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
        txn_end     = 1'b0;
        timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);
        discard_now = discard_q | flush;

        // Clears come first so a completion in the same cycle still sets done.
        if (advance) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end
        if (flush) begin
            if_done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_req && !mem_done_q) begin
                    state_d     = DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_be_d    = mem_we ? mem_be : '1;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_req && !if_done_q && !flush) begin
                    state_d     = INST;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                end
            end
            DATA: begin
                if (bus_ack) begin
                    mem_done_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                    txn_end = 1'b1;
                end else if (timeout_hit) begin
                    mem_done_d  = 1'b1;
                    mem_rdata_d = '0;
                    bus_err_d   = 1'b1;
                    txn_end     = 1'b1;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            INST: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (bus_ack) begin
                    if (!discard_now) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                    txn_end = 1'b1;
                end else if (timeout_hit) begin
                    if (!discard_now) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                    bus_err_d = 1'b1;
                    txn_end   = 1'b1;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (txn_end) begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
            discard_d = 1'b0;
            cnt_d     = '0;
        end
    end

    // State and registered outputs; reset drops bus_req immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // The pipeline must never advance while this block is stalling it.
    a_no_advance_in_stall: assert property (@(posedge clk) disable iff (!resetn)
        !(advance && stall_req));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, flush, watchdog and async reset.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          resetn;
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          advance;
    logic          flush;
    logic          stall_if;
    logic          stall_mem;
    logic          stall_req;
    logic          bus_req;
    logic          bus_we;
    logic [3:0]    bus_be;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_ack;
    logic [31:0]   bus_rdata;
    logic          bus_err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .advance   (advance),
        .flush     (flush),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .stall_req (stall_req),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        bit           is_mem;
        bit           we;
        logic [3:0]   be;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           delay;      // bus_req cycle in which the bus acks (1 = first)
        logic [31:0]  rdata;      // value the bus returns with ack
        logic [3:0]   exp_be;
        logic [31:0]  exp_rdata;  // rdata output expected once done
    } vec_t;

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
    } sb_t;

    vec_t        vecs[6];
    sb_t         sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    bit          m_err    = 1'b0;
    logic [31:0] m_if_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string nm);
        sb_t it;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            it = sb.pop_front();
            chk({nm, "_rdata"}, it.is_mem ? mem_rdata : if_rdata, it.rdata);
        end
    endtask

    // Drive one request, answer it as the bus, then check hold and release on advance.
    task automatic run_txn(input vec_t v);
        int req_n;
        int stall_n;
        bit got;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_be = v.be;
            mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        sb.push_back('{v.is_mem, v.exp_rdata});
        #1;
        req_n = 0; stall_n = 0; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!stall_req) begin
                got = 1'b1;
                break;
            end
            stall_n++;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    chk({v.name, "_bus_addr"}, bus_addr, v.addr);
                    chk({v.name, "_bus_we"}, 32'(bus_we), 32'(v.we));
                    chk({v.name, "_bus_be"}, 32'(bus_be), 32'(v.exp_be));
                    if (v.we) chk({v.name, "_bus_wdata"}, bus_wdata, v.wdata);
                end
                if (req_n == v.delay) begin
                    bus_ack = 1'b1;
                    bus_rdata = v.rdata;
                end
            end
            step();
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            #1;
        end
        chk({v.name, "_completed"}, 32'(got), 32'(1));
        chk({v.name, "_bus_req_cycles"}, 32'(req_n), 32'(v.delay));
        chk({v.name, "_stall_cycles"}, 32'(stall_n), 32'(v.delay + 1));
        chk({v.name, "_bus_req_low"}, 32'(bus_req), 32'(0));
        chk({v.name, "_bus_err"}, 32'(bus_err), 32'(m_err));
        sb_check(v.name);
        step();
        #1;
        chk({v.name, "_held_stall"}, 32'(stall_req), 32'(0));
        chk({v.name, "_held_rdata"}, v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        advance = 1'b1;
        step();
        advance = 1'b0;
        #1;
        chk({v.name, "_done_cleared"}, 32'(stall_req), 32'(1));
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        step();
        #1;
        chk({v.name, "_no_new_txn"}, 32'(bus_req), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stall_n;
        int req_n;
        int n_tx;
        logic [31:0] txa[2];
        bit got;

        resetn = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_be = '0; mem_addr = '0; mem_wdata = '0; advance = 1'b0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;

        vecs[0] = '{"load3",  1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,          3, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        vecs[1] = '{"store2", 1'b1, 1'b1, 4'h3, 32'h0000_0104, 32'h1234_5678,  2, 32'hCAFE_F00D, 4'h3, 32'hDEAD_BEEF};
        vecs[2] = '{"fetch1", 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,          1, 32'h0000_0013, 4'hF, 32'h0000_0013};
        vecs[3] = '{"load8",  1'b1, 1'b0, 4'h0, 32'h0000_0108, 32'h0,          8, 32'hA5A5_5A5A, 4'hF, 32'hA5A5_5A5A};
        vecs[4] = '{"fetch2", 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,          2, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
        vecs[5] = '{"store1", 1'b1, 1'b1, 4'hF, 32'h0000_010C, 32'h0F0F_0F0F,  1, 32'h0000_0055, 4'hF, 32'hA5A5_5A5A};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'(0));
        chk("rst_bus_we", 32'(bus_we), 32'(0));
        chk("rst_bus_be", 32'(bus_be), 32'(0));
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'(0));
        chk("rst_stall_req", 32'(stall_req), 32'(0));
        resetn = 1'b1;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);
        m_if_rdata = 32'hFFFF_FFFF;

        // Both requests in one cycle: data first, then fetch.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h40;
        sb.push_back('{1'b1, 32'h1111_2222});
        sb.push_back('{1'b0, 32'h3333_4444});
        #1;
        n_tx = 0; stall_n = 0;
        txa[0] = '0; txa[1] = '0;
        for (int c = 0; c < 40; c++) begin
            if (!stall_req) break;
            stall_n++;
            if (bus_req && n_tx < 2) begin
                txa[n_tx] = bus_addr;
                bus_ack = 1'b1;
                bus_rdata = (n_tx == 0) ? 32'h1111_2222 : 32'h3333_4444;
                n_tx++;
            end
            step();
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            #1;
        end
        chk("dual_txn_count", 32'(n_tx), 32'(2));
        chk("dual_first_addr", txa[0], 32'h200);
        chk("dual_second_addr", txa[1], 32'h40);
        chk("dual_stall_cycles", 32'(stall_n), 32'(4));
        sb_check("dual_mem");
        sb_check("dual_if");
        advance = 1'b1;
        step();
        advance = 1'b0; mem_req = 1'b0; if_req = 1'b0;
        m_if_rdata = 32'h3333_4444;
        step();

        // Flush while the fetch is on the bus: its result is discarded, then a refetch runs.
        if_req = 1'b1; if_addr = 32'h80;
        step();
        chk("flush_bus_req", 32'(bus_req), 32'(1));
        chk("flush_bus_addr", bus_addr, 32'h80);
        flush = 1'b1;
        step();
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        step();
        bus_ack = 1'b0;
        #1;
        chk("flush_bus_req_low", 32'(bus_req), 32'(0));
        chk("flush_if_not_done", 32'(stall_if), 32'(1));
        chk("flush_if_rdata_kept", if_rdata, m_if_rdata);
        step();
        chk("flush_refetch", 32'(bus_req), 32'(1));
        bus_ack = 1'b1; bus_rdata = 32'h0000_0093;
        step();
        bus_ack = 1'b0;
        #1;
        chk("refetch_done", 32'(stall_if), 32'(0));
        chk("refetch_rdata", if_rdata, 32'h0000_0093);
        flush = 1'b1; if_req = 1'b0;
        step();
        flush = 1'b0; if_req = 1'b1;
        #1;
        chk("flush_clears_done", 32'(stall_if), 32'(1));
        if_req = 1'b0;
        step();

        // Watchdog: a load that never gets an ack.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
        sb.push_back('{1'b1, 32'h0});
        #1;
        req_n = 0; stall_n = 0; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!stall_req) begin
                got = 1'b1;
                break;
            end
            stall_n++;
            if (bus_req) req_n++;
            step();
            #1;
        end
        chk("wdog_released", 32'(got), 32'(1));
        chk("wdog_bus_req_cycles", 32'(req_n), 32'(8));
        chk("wdog_stall_cycles", 32'(stall_n), 32'(9));
        chk("wdog_bus_err", 32'(bus_err), 32'(1));
        sb_check("wdog");
        m_err = 1'b1;
        advance = 1'b1;
        step();
        advance = 1'b0; mem_req = 1'b0;
        step();
        run_txn('{"sticky", 1'b0, 1'b0, 4'h0, 32'h44, 32'h0, 1, 32'h77, 4'hF, 32'h77});

        // Reset in the middle of a data transaction.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
        step();
        chk("rstmid_bus_req", 32'(bus_req), 32'(1));
        #2;
        resetn = 1'b0;
        #1;
        chk("rstmid_bus_req_async", 32'(bus_req), 32'(0));
        chk("rstmid_bus_err", 32'(bus_err), 32'(0));
        chk("rstmid_mem_rdata", mem_rdata, 32'h0);
        chk("rstmid_if_rdata", if_rdata, 32'h0);
        chk("rstmid_bus_addr", bus_addr, 32'h0);
        mem_req = 1'b0;
        step();
        resetn = 1'b1;
        step();
        step();
        chk("rstmid_idle_bus_req", 32'(bus_req), 32'(0));
        chk("rstmid_idle_stall", 32'(stall_req), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
